// File: rtl/i2c_reg_target.sv
// I2C register target: 3-byte register writes [addr+W, sub, data...] and pointer-based reads.
// SCL/SDA are synchronised and glitch-filtered on iCLK; SDA is driven open-drain only.
module i2c_reg_target #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h10,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       oWR_STB,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  output logic [7:0] oRD_ADDR,
  input  logic [7:0] iRD_DATA,
  output logic       oBUSY
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_e;

  // Index 1 = SCL, index 0 = SDA.
  logic [1:0]    sync1_q, sync2_q, filt_q, filt_prev_q;
  logic [CW-1:0] cnt_q [2];

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      filt_q      <= '1;
      filt_prev_q <= '1;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= {I2C_SCLK, I2C_SDAT};
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      // A new level is accepted only after it differs from the filtered level FILT_LEN cycles in a row.
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_f     = filt_q[1];
  assign sda_f     = filt_q[0];
  assign scl_rise  = scl_f & ~filt_prev_q[1];
  assign scl_fall  = ~scl_f & filt_prev_q[1];
  assign start_det = scl_f & filt_prev_q[1] & filt_prev_q[0] & ~sda_f;
  assign stop_det  = scl_f & filt_prev_q[1] & ~filt_prev_q[0] & sda_f;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, tx_q, tx_d, ptr_q, ptr_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic       sda_low_q, sda_low_d, busy_q, busy_d, wr_stb_q, wr_stb_d;

  assign rx_byte = {shift_q[6:0], sda_f};

  // NOTE: every next-state variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    sda_low_d = sda_low_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (stop_det) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      sda_low_d = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, SUB, WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7 && state_q == SUB) ptr_d = rx_byte;
            if (bit_cnt_q == 4'd7 && state_q == WDATA) begin
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = rx_byte;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            // Entered on the fall after bit 0, so the next fall ends the ACK clock.
            sda_low_d = 1'b1;
            unique case (state_q)
              ADDR: begin
                if (shift_q[7:1] == SLAVE_ADDR) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                end else begin
                  state_d   = IGNORE;
                  sda_low_d = 1'b0;
                end
              end
              SUB:     state_d = SUB_ACK;
              default: begin
                state_d = WDATA_ACK;
                ptr_d   = ptr_q + 8'd1;
              end
            endcase
          end
        end
        ADDR_ACK, RDATA_ACK: begin
          if (state_q == RDATA_ACK && scl_rise) begin
            if (sda_f) state_d = IGNORE;
            else       ptr_d   = ptr_q + 8'd1;
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            if (state_q == RDATA_ACK || shift_q[0]) begin
              state_d   = RDATA;
              tx_d      = {iRD_DATA[6:0], 1'b0};
              sda_low_d = ~iRD_DATA[7];
            end else begin
              state_d = SUB;
            end
          end
        end
        SUB_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_d   = WDATA;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = RDATA_ACK;
              sda_low_d = 1'b0;
            end else begin
              sda_low_d = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the async reset clears sda_low_q at once, so a reset mid-ACK frees the bus without a clock.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      sda_low_q <= sda_low_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;
  assign oWR_STB  = wr_stb_q;
  assign oWR_ADDR = wr_addr_q;
  assign oWR_DATA = wr_data_q;
  assign oRD_ADDR = ptr_q;
  assign oBUSY    = busy_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged initiator, write strobes checked by a scoreboard monitor.
`timescale 1ns/1ps
module tb_i2c_reg_target;

  localparam int T = 10;  // quarter SCL period in iCLK cycles

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv_low = 1'b0;
  wire        sda_bus;
  logic       wr_stb, busy;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data = 8'h00;

  int   n_checks = 0;
  int   n_errors = 0;
  int   drive_seen = 0;
  logic watch_nodrive = 1'b0;
  wr_t  exp_q[$];

  assign sda_bus = sda_drv_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_reg_target #(.SLAVE_ADDR(7'h10), .FILT_LEN(3)) dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .I2C_SCLK (scl_drv),
    .I2C_SDAT (sda_bus),
    .oWR_STB  (wr_stb),
    .oWR_ADDR (wr_addr),
    .oWR_DATA (wr_data),
    .oRD_ADDR (rd_addr),
    .iRD_DATA (rd_data),
    .oBUSY    (busy)
  );

  // Register-file model: returns addr + 0x40 one cycle after the pointer moves.
  always @(posedge clk) rd_data <= rd_addr + 8'h40;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_stb === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (watch_nodrive && sda_bus === 1'b0 && !sda_drv_low) drive_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock starting just after SCL fell. glitch: 1 = SCL pulse in low phase, 2 = SDA pulse in high phase.
  task automatic send_bit(input logic b, input int glitch, output logic sampled);
    tick(T);
    sda_drv_low = ~b;
    if (glitch == 1) begin
      tick(T / 2); scl_drv = 1'b1; tick(1); scl_drv = 1'b0; tick(T - T / 2 - 1);
    end else begin
      tick(T);
    end
    scl_drv = 1'b1;
    if (glitch == 2) begin
      tick(T / 2); sda_drv_low = ~sda_drv_low; tick(2); sda_drv_low = ~sda_drv_low; tick(T - T / 2 - 2);
    end else begin
      tick(T);
    end
    sampled = sda_bus;
    tick(T);
    scl_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_n);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], 0, s);
    send_bit(1'b1, 0, ack_n);
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 0, s);
      b[i] = s;
    end
    send_bit(~ack, 0, s);
  endtask

  task automatic i2c_start();
    sda_drv_low = 1'b0;
    tick(2 * T);
    scl_drv = 1'b1;
    tick(2 * T);
    sda_drv_low = 1'b1;
    tick(2 * T);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(T);
    sda_drv_low = 1'b1;
    tick(T);
    scl_drv = 1'b1;
    tick(2 * T);
    sda_drv_low = 1'b0;
    tick(2 * T);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    logic       ack_n, s;
    logic [7:0] rb;
    logic [7:0] glitch_byte;

    tick(4);
    check("reset_sda",     32'(sda_bus), 32'h1);
    check("reset_wr_stb",  32'(wr_stb),  32'h0);
    check("reset_wr_addr", 32'(wr_addr), 32'h0);
    check("reset_wr_data", 32'(wr_data), 32'h0);
    check("reset_rd_addr", 32'(rd_addr), 32'h0);
    check("reset_busy",    32'(busy),    32'h0);
    rst_n = 1'b1;
    tick(4 * T);

    // 1: single register write
    i2c_start();
    send_byte(8'h20, ack_n); check("t1_ack_addr", 32'(ack_n), 32'h0);
    check("t1_busy_after_addr", 32'(busy), 32'h1);
    send_byte(8'h02, ack_n); check("t1_ack_sub", 32'(ack_n), 32'h0);
    push_wr(8'h02, 8'h27);
    send_byte(8'h27, ack_n); check("t1_ack_data", 32'(ack_n), 32'h0);
    i2c_stop();
    check("t1_busy_after_stop", 32'(busy), 32'h0);
    check("t1_rd_addr", 32'(rd_addr), 32'h03);

    // 2: address mismatch
    watch_nodrive = 1'b1;
    i2c_start();
    send_byte(8'hC0, ack_n); check("t2_nack_addr", 32'(ack_n), 32'h1);
    check("t2_busy", 32'(busy), 32'h0);
    send_byte(8'h02, ack_n); check("t2_nack_b1", 32'(ack_n), 32'h1);
    send_byte(8'h53, ack_n); check("t2_nack_b2", 32'(ack_n), 32'h1);
    i2c_stop();
    watch_nodrive = 1'b0;
    check("t2_sda_never_driven", 32'(drive_seen), 32'h0);
    check("t2_busy_end", 32'(busy), 32'h0);

    // 3: burst write across pointer wrap
    i2c_start();
    send_byte(8'h20, ack_n); check("t3_ack_addr", 32'(ack_n), 32'h0);
    send_byte(8'hFF, ack_n); check("t3_ack_sub", 32'(ack_n), 32'h0);
    push_wr(8'hFF, 8'h11);
    send_byte(8'h11, ack_n); check("t3_ack_d0", 32'(ack_n), 32'h0);
    push_wr(8'h00, 8'h22);
    send_byte(8'h22, ack_n); check("t3_ack_d1", 32'(ack_n), 32'h0);
    i2c_stop();
    check("t3_rd_addr", 32'(rd_addr), 32'h01);

    // 4: set pointer, repeated START, read two bytes
    i2c_start();
    send_byte(8'h20, ack_n); check("t4_ack_addr_w", 32'(ack_n), 32'h0);
    send_byte(8'h05, ack_n); check("t4_ack_sub", 32'(ack_n), 32'h0);
    i2c_start();
    send_byte(8'h21, ack_n); check("t4_ack_addr_r", 32'(ack_n), 32'h0);
    recv_byte(1'b1, rb); check("t4_rd_byte0", 32'(rb), 32'h45);
    recv_byte(1'b0, rb); check("t4_rd_byte1", 32'(rb), 32'h46);
    tick(T);
    check("t4_sda_released", 32'(sda_bus), 32'h1);
    i2c_stop();
    check("t4_rd_addr", 32'(rd_addr), 32'h06);

    // 5: glitches on SCL (low phase) and SDA (high phase) inside a data byte
    glitch_byte = 8'hA5;
    i2c_start();
    send_byte(8'h20, ack_n); check("t5_ack_addr", 32'(ack_n), 32'h0);
    send_byte(8'h30, ack_n); check("t5_ack_sub", 32'(ack_n), 32'h0);
    push_wr(8'h30, 8'hA5);
    for (int i = 7; i >= 0; i--) send_bit(glitch_byte[i], (i == 3) ? 1 : ((i == 2) ? 2 : 0), s);
    send_bit(1'b1, 0, ack_n); check("t5_ack_data", 32'(ack_n), 32'h0);
    check("t5_busy_held", 32'(busy), 32'h1);
    i2c_stop();
    check("t5_rd_addr", 32'(rd_addr), 32'h31);

    // 6: reset during the SUB ACK slot, then a fresh write
    i2c_start();
    send_byte(8'h20, ack_n); check("t6_ack_addr", 32'(ack_n), 32'h0);
    for (int i = 7; i >= 0; i--) send_bit(1'((8'h33 >> i) & 8'h01), 0, s);
    tick(T);
    check("t6_ack_driven", 32'(sda_bus), 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6_sda_released_in_reset", 32'(sda_bus), 32'h1);
    check("t6_busy_in_reset", 32'(busy), 32'h0);
    check("t6_rd_addr_in_reset", 32'(rd_addr), 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(T);
    scl_drv = 1'b1;
    tick(4 * T);
    i2c_start();
    send_byte(8'h20, ack_n); check("t6_ack_addr2", 32'(ack_n), 32'h0);
    send_byte(8'h10, ack_n); check("t6_ack_sub2", 32'(ack_n), 32'h0);
    push_wr(8'h10, 8'h0F);
    send_byte(8'h0F, ack_n); check("t6_ack_data2", 32'(ack_n), 32'h0);
    i2c_stop();

    tick(20);
    check("pending_strobes", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
